dmem_arbiter: RTL

Two-requester arbiter in front of the single-port synchronous data memory `dmem` (12-bit word address, 32-bit data, 1-cycle registered read). It shares the memory between the CPU load/store unit (port 0) and the debug/program-loader port (port 1). It grants at most one access per cycle, supports bounded locked bursts, and returns read data with a per-port valid strobe.

---
 rtl/dmem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data memory between the
// CPU load/store unit (port 0) and the debug/program-loader port (port 1).
// At most one access is granted per cycle. The grant is combinational, so an
// access reaches the memory in the same cycle it is requested. Locked bursts
// are bounded by LOCK_MAX, and read data returns with a per-port valid strobe
// one cycle after the grant.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration in IDLE.
// Without it, port 0 has fixed priority over port 1.
module dmem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

    // lock_cnt counts grants already given in the current ownership. When it
    // reaches LOCK_LAST, the grant being given now is the LOCK_MAX-th, and
    // ownership is released.
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

    // Per-port views, indexed by port number
    logic [1:0]         req, we, lock;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;

    assign req   = {m1_req, m0_req};
    assign we    = {m1_we, m0_we};
    assign lock  = {m1_lock, m0_lock};
    assign addr  = {m1_addr, m0_addr};
    assign wdata = {m1_wdata, m0_wdata};

    state_e        state_q, state_d;
    logic [7:0]    lock_cnt_q, lock_cnt_d;
    logic          fprio_q, fprio_d;    // one-shot priority after a forced release
    logic          fport_q, fport_d;    // port that receives that priority
    logic [1:0]    rvalid_q;
    logic [AW-1:0] addr_q;              // last granted address, held while idle
    logic [1:0]    gnt;
    logic          gport;               // granted port, meaningful when |gnt
    logic          own;
    logic          pol_pref;            // port preferred by the arbitration policy
    logic          pref;
    logic          win;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    assign pol_pref = rr_ptr_q;

    // Hand preference to the other port after any grant that leaves the FSM in IDLE
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|gnt && state_d == IDLE) rr_ptr_d = ~gport;
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    assign pol_pref = 1'b0;
`endif

    // The one-shot priority from a forced release overrides the policy.
    // With two ports, the preferred port wins whenever it requests.
    assign pref = fprio_q ? fport_q : pol_pref;
    assign win  = req[pref] ? pref : ~pref;

    // Grant selection and next-state logic for ownership and the lock counter
    always_comb begin
        gnt        = 2'b00;
        gport      = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        fprio_d    = 1'b0;
        fport_d    = fport_q;
        own        = (state_q == OWN1);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gport    = win;
                    gnt[win] = 1'b1;
                    if (lock[win]) begin
                        state_d    = win ? OWN1 : OWN0;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            OWN0, OWN1: begin
                // Fall back to IDLE unless the owner keeps the lock below the bound
                state_d    = IDLE;
                lock_cnt_d = 8'd0;
                if (req[own]) begin
                    gport    = own;
                    gnt[own] = 1'b1;
                    if (lock_cnt_q >= LOCK_LAST) begin
                        fprio_d = 1'b1;
                        fport_d = ~own;
                    end else if (lock[own]) begin
                        state_d    = state_q;
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = 8'd0;
            end
        endcase
        // No access may reach the memory while reset is asserted
        if (!rst_n) gnt = 2'b00;
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign mem_we    = |(gnt & we);
    assign mem_addr  = (|gnt) ? addr[gport] : addr_q;
    assign mem_din   = wdata[gport];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = mem_dout;
    assign m1_rdata  = mem_dout;

    // FSM state, lock bookkeeping, read-valid strobes and held address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_cnt_q <= 8'd0;
            fprio_q    <= 1'b0;
            fport_q    <= 1'b0;
            rvalid_q   <= 2'b00;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            fprio_q    <= fprio_d;
            fport_q    <= fport_d;
            rvalid_q   <= gnt & ~we;
            addr_q     <= mem_addr;
        end
    end

endmodule
